// File: rtl/seg7_status_display.sv
// seg7_status_display
//   Page sequencer for the irrigation controller's 4-digit common-anode
//   7-segment display. A slow divider tick rotates LEVEL -> MODE -> VALVE;
//   an alarm pre-empts the rotation and blinks "E--E" on each tick.
//   The system clock multiplexes the four digits.
// Ports
//   clk       system clock
//   reset     async active-low reset
//   tick_in   divider square wave, asynchronous to clk
//   level     reservoir level 0..3
//   mode      0 = sprinkler, 1 = drip
//   valve_on  1 = valve open
//   alarm     fault flag (clk domain, level-sensitive)
//   seg_n     segments {g,f,e,d,c,b,a}, active-low
//   an_n      digit enables, active-low, an_n[3] = leftmost
module seg7_status_display #(
   parameter int SCAN_DIV   = 12500,
   parameter int PAGE_TICKS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_in,
   input  logic [1:0] level,
   input  logic       mode,
   input  logic       valve_on,
   input  logic       alarm,
   output logic [6:0] seg_n,
   output logic [3:0] an_n
);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int TW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;

   localparam logic [6:0] G_L     = 7'b1000111;
   localparam logic [6:0] G_A     = 7'b0001000;
   localparam logic [6:0] G_F     = 7'b0001110;
   localparam logic [6:0] G_E     = 7'b0000110;
   localparam logic [6:0] G_DASH  = 7'b0111111;
   localparam logic [6:0] G_BLANK = 7'b1111111;

   typedef enum logic [1:0] {LEVEL, MODE, VALVE, ALARM} state_t;

   state_t        state;
   logic [TW-1:0] tcnt;
   logic [SW-1:0] scnt;
   logic [1:0]    k;
   logic          blink;
   logic          sync1, sync2, sync2_d;
   logic          tick;
   logic [6:0]    nxt_seg;
   logic [3:0]    nxt_an;

   function automatic logic [6:0] num_glyph(input logic [1:0] v);
      case (v)
         2'd0:    num_glyph = 7'b1000000;
         2'd1:    num_glyph = 7'b1111001;
         2'd2:    num_glyph = 7'b0100100;
         default: num_glyph = 7'b0110000;
      endcase
   endfunction

   // one-clk pulse per rising edge of the synchronized tick
   assign tick = sync2 & ~sync2_d;

   // glyph for the digit being scanned; inputs are used live
   always_comb begin
      logic [6:0] left, right;
      left  = G_L;
      right = num_glyph(level);
      case (state)
         LEVEL: begin left = G_L; right = num_glyph(level); end
         MODE:  begin left = G_A; right = num_glyph({1'b0, mode} + 2'd1); end
         VALVE: begin left = G_F; right = num_glyph({1'b0, valve_on}); end
         default: begin left = G_E; right = G_E; end
      endcase
      nxt_an = ~(4'b0001 << k);
      if (state == ALARM && blink)
         nxt_seg = G_BLANK;
      else if (k == 2'd3)
         nxt_seg = left;
      else if (k == 2'd0)
         nxt_seg = right;
      else
         nxt_seg = G_DASH;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_d <= 1'b0;
         state   <= LEVEL;
         tcnt    <= '0;
         blink   <= 1'b0;
         scnt    <= '0;
         k       <= 2'd0;
         seg_n   <= 7'h7F;
         an_n    <= 4'hF;
      end else begin
         sync1   <= tick_in;
         sync2   <= sync1;
         sync2_d <= sync2;

         // segments and enables come from the same k, so they stay aligned
         seg_n <= nxt_seg;
         an_n  <= nxt_an;

         if (scnt == SW'(SCAN_DIV - 1)) begin
            scnt <= '0;
            k    <= k + 2'd1;
         end else begin
            scnt <= scnt + 1'b1;
         end

         if (state == ALARM) begin
            if (!alarm) begin
               state <= LEVEL;
               tcnt  <= '0;
               blink <= 1'b0;
            end else if (tick) begin
               blink <= ~blink;
            end
         end else if (alarm) begin
            // alarm wins over a same-cycle tick, which is dropped
            state <= ALARM;
            tcnt  <= '0;
            blink <= 1'b0;
         end else if (tick) begin
            if (tcnt == TW'(PAGE_TICKS - 1)) begin
               tcnt <= '0;
               case (state)
                  LEVEL:   state <= MODE;
                  MODE:    state <= VALVE;
                  default: state <= LEVEL;
               endcase
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/seg7_status_display.md
# seg7_status_display

Status display sequencer for the irrigation controller's 4-digit, common-anode 7-segment display. It sits directly downstream of the 7-segment clock divider: it consumes the divider's slow square wave (~0.745 Hz) as a page/blink tick, while the system clock drives digit multiplexing. It rotates through reservoir level, irrigation mode and valve pages. An alarm page pre-empts the rotation and blinks.

## Interface
Parameters:
- SCAN_DIV, 12500: system clocks per digit slot (50 MHz gives 4 kHz per slot, 1 kHz full refresh); must be ≥2.
- PAGE_TICKS, 2: slow-tick rising edges per page.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- tick_in  in  1  divider output (clk7seg); not synchronous to clk.
- level  in  2  reservoir level 0..3.
- mode  in  1  0 = sprinkler, 1 = drip.
- valve_on  in  1  1 = valve open.
- alarm  in  1  fault flag, level-sensitive.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an_n  out  4  digit enables, active-low; an_n[3] is the leftmost digit.

## Operation
- tick_in passes through a 2-FF synchronizer.
- tick = sync2 & ~sync2_d, a one-clk pulse per tick_in rising edge.
- Page FSM states: LEVEL, MODE, VALVE, ALARM. Reset state is LEVEL.
- Tick counter tcnt runs 0..PAGE_TICKS-1:
  - A tick with tcnt = PAGE_TICKS-1 clears tcnt and advances the page: LEVEL→MODE→VALVE→LEVEL.
  - Any other tick increments tcnt.
- alarm = 1 in any non-ALARM state:
  - Next state is ALARM; tcnt is cleared and blink is cleared to 0.
  - This takes priority over a same-cycle tick, which is discarded.
- In ALARM, each tick toggles blink.
- alarm = 0 in ALARM: next state is LEVEL, with tcnt = 0 and blink = 0.
- Page contents, listed digit3..digit0:
  - LEVEL: "L","-","-",level.
  - MODE: "A","-","-",mode+1, so sprinkler shows 1 and drip shows 2.
  - VALVE: "F","-","-",valve_on.
  - ALARM: "E","-","-","E" when blink = 0; all blank when blink = 1.
- Glyphs (seg_n):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - L = 1000111, A = 0001000, F = 0001110, E = 0000110
  - "-" = 0111111, blank = 1111111
- Data inputs are sampled live every clk; no snapshot is taken at page entry.
- Scan:
  - scnt runs 0..SCAN_DIV-1.
  - On wrap, digit index k advances 0→1→2→3→0.
  - Digit k drives an_n[k] = 0 with all other enables high, and seg_n carries digit k's glyph.
- seg_n and an_n are registered together, so they never disagree on the digit for even one cycle.

## Timing
- Reset values:
  - seg_n = 7'h7F, an_n = 4'hF.
  - State LEVEL; tcnt, scnt, k and blink all 0.
  - Synchronizer flops 0.
- First clk edge after reset release: an_n = 1110, seg_n = glyph of level.
- Tick latency:
  - tick_in is first sampled high at edge N.
  - tick pulse is high between edges N+1 and N+2.
  - State/tcnt update at edge N+2.
  - seg_n/an_n reflect the new page at edge N+3.
- Alarm latency: alarm is sampled high at edge N, state becomes ALARM at N, and outputs show it at N+1. There is no synchronizer on alarm; it is already clk-domain.
- Digit dwell is exactly SCAN_DIV clks. A page change mid-slot updates that slot's glyph with no re-alignment of the scan.
- A tick_in held high produces exactly one tick. A tick_in pulse shorter than one clk may be missed, which is acceptable for the divider output.
- Asserting reset mid-page or mid-alarm returns everything to the reset values asynchronously.

## Test plan
- Reset/scan (SCAN_DIV = 4, level = 2):
  - Reset low gives seg_n = 7F, an_n = F.
  - After release: an_n = 1110 for 4 clks with seg_n = 0100100, then 1101 with seg_n = 0111111, then 1011 with seg_n = 0111111, then 0111 with seg_n = 1000111, then back to 1110.
- Rotation (PAGE_TICKS = 2; mode = 1, valve_on = 1):
  - After 2 tick_in rises, digit0 = 0100100 (MODE, "2").
  - After 4 rises, digit0 = 1111001 and digit3 = 0001110 (VALVE).
  - After 6 rises, the display is back on LEVEL.
- Tick latency: tick_in rise sampled at edge N → page-dependent seg_n changes at edge N+3, not earlier.
- Alarm pre-emption:
  - Raise alarm together with a tick pulse in VALVE → next cycle the display shows E--E.
  - Each following tick alternates blank / E--E.
  - Drop alarm → LEVEL on the next edge, and 2 more ticks are needed to reach MODE.
- Reset mid-operation: assert reset while in ALARM with blink = 1 → outputs are 7F/F immediately, without waiting for a clock edge. After release, the display shows LEVEL.
